// File: rtl/alu_issue_arb.sv
// ----------------------------------------------------------------------------
// alu_issue_arb
//
// Shares one ALU between the two issue lanes of the superscalar core. A
// round-robin arbiter grants at most one lane per cycle. The granted operands
// go through the ALU, and the result, tag and lane id land in a one-entry
// output register. That register has a valid/ready handshake toward
// writeback. The block also holds the architectural NZCV flag register, which
// only ops with setf=1 update.
//
// Data width comes from the `D_WIDTH macro, normally supplied by param.v. It
// falls back to 32 if no definition is present.
//
// Optional build macro: ALU_ARB_PERF_EN adds saturating performance counters
// (o_cnt0, o_cnt1, o_stall).
//
// Ports (alu_issue_arb):
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_v0/1, o_rdy0/1      per-lane op valid / op accepted this cycle
//   i_a0/1, i_b0/1        per-lane operands
//   i_ctl0/1              00 A+B, 01 A-B, 10 pass B, 11 pass A
//   i_tag0/1, i_setf0/1   per-lane tag, op writes the flag register
//   o_v, i_rdy            output register valid / writeback consumes it
//   o_result, o_tag       registered result and tag
//   o_lane                lane that issued the held result
//   o_flag                architectural flags {N,Z,C,V}
//   o_cnt0/1, o_stall     (ALU_ARB_PERF_EN only) grant and stall counters
// ----------------------------------------------------------------------------
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

// Combinational ALU. It reports flags {N,Z,C,V}, with C tied to 0.
module alu (
    input  logic [`D_WIDTH-1:0] i_a,
    input  logic [`D_WIDTH-1:0] i_b,
    input  logic [1:0]          i_ctl,
    output logic [`D_WIDTH-1:0] o_result,
    output logic [3:0]          o_Flag
);
    localparam int MSB = `D_WIDTH - 1;

    logic [`D_WIDTH-1:0] sum;
    logic [`D_WIDTH-1:0] diff;
    logic                ovf;

    assign sum  = i_a + i_b;
    assign diff = i_a - i_b;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        o_result = '0;
        ovf      = 1'b0;
        case (i_ctl)
            2'b00: begin
                o_result = sum;
                ovf      = (i_a[MSB] == i_b[MSB]) && (sum[MSB] != i_a[MSB]);
            end
            2'b01: begin
                o_result = diff;
                ovf      = (i_a[MSB] != i_b[MSB]) && (diff[MSB] != i_a[MSB]);
            end
            2'b10: o_result = i_b;
            2'b11: o_result = i_a;
        endcase
    end

    assign o_Flag = {o_result[MSB], (o_result == '0), 1'b0, ovf};
endmodule

module alu_issue_arb #(
    parameter int TAG_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_v0,
    input  logic                i_v1,
    output logic                o_rdy0,
    output logic                o_rdy1,
    input  logic [`D_WIDTH-1:0] i_a0,
    input  logic [`D_WIDTH-1:0] i_a1,
    input  logic [`D_WIDTH-1:0] i_b0,
    input  logic [`D_WIDTH-1:0] i_b1,
    input  logic [1:0]          i_ctl0,
    input  logic [1:0]          i_ctl1,
    input  logic [TAG_W-1:0]    i_tag0,
    input  logic [TAG_W-1:0]    i_tag1,
    input  logic                i_setf0,
    input  logic                i_setf1,
    output logic                o_v,
    input  logic                i_rdy,
    output logic [`D_WIDTH-1:0] o_result,
    output logic [TAG_W-1:0]    o_tag,
    output logic                o_lane,
    output logic [3:0]          o_flag
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]         o_cnt0,
    output logic [15:0]         o_cnt1,
    output logic [15:0]         o_stall
`endif
);
    logic                acc;        // output register can take a new result
    logic                gnt_any;    // some lane is being granted
    logic                gnt_lane;   // which lane wins arbitration
    logic                r_last;     // lane granted most recently
    logic [`D_WIDTH-1:0] alu_a;
    logic [`D_WIDTH-1:0] alu_b;
    logic [1:0]          alu_ctl;
    logic [`D_WIDTH-1:0] alu_res;
    logic [3:0]          alu_flag;
    logic                sel_setf;
    logic [TAG_W-1:0]    sel_tag;

    // The slot is free when it is empty or is being drained this cycle.
    // A consume and a new load can therefore happen on the same edge.
    assign acc = !o_v || i_rdy;

    // Round robin. With both lanes valid, the lane that did not win last time
    // takes the grant. r_last resets to 1 so that lane 0 wins first.
    always_comb begin
        gnt_any  = acc && (i_v0 || i_v1);
        gnt_lane = 1'b0;
        if (i_v0 && i_v1) gnt_lane = !r_last;
        else if (i_v1)    gnt_lane = 1'b1;
    end

    assign o_rdy0 = gnt_any && !gnt_lane;
    assign o_rdy1 = gnt_any &&  gnt_lane;

    // With no grant, gnt_lane is 0, so lane 0 drives the ALU. That result is
    // never captured.
    always_comb begin
        alu_a    = i_a0;
        alu_b    = i_b0;
        alu_ctl  = i_ctl0;
        sel_tag  = i_tag0;
        sel_setf = i_setf0;
        if (gnt_lane) begin
            alu_a    = i_a1;
            alu_b    = i_b1;
            alu_ctl  = i_ctl1;
            sel_tag  = i_tag1;
            sel_setf = i_setf1;
        end
    end

    alu u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_ctl    (alu_ctl),
        .o_result (alu_res),
        .o_Flag   (alu_flag)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_v      <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
            o_lane   <= 1'b0;
            o_flag   <= 4'b0000;
            r_last   <= 1'b1;
        end else if (acc) begin
            if (gnt_any) begin
                o_v      <= 1'b1;
                o_result <= alu_res;
                o_tag    <= sel_tag;
                o_lane   <= gnt_lane;
                r_last   <= gnt_lane;
                if (sel_setf) o_flag <= alu_flag;
            end else begin
                o_v <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Saturating event counters. They stop at 16'hFFFF instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt0  <= '0;
            o_cnt1  <= '0;
            o_stall <= '0;
        end else begin
            if (o_rdy0 && o_cnt0 != 16'hFFFF) o_cnt0 <= o_cnt0 + 16'd1;
            if (o_rdy1 && o_cnt1 != 16'hFFFF) o_cnt1 <= o_cnt1 + 16'd1;
            if ((i_v0 || i_v1) && !acc && o_stall != 16'hFFFF)
                o_stall <= o_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_arb.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_arb
//
// Directed bench for alu_issue_arb. A table of single-cycle vectors covers
// the arithmetic, flag and handshake cases. Hand-written sequences cover
// round-robin alternation, back-pressure, asynchronous reset and (when
// ALU_ARB_PERF_EN is defined) the performance counters.
// ----------------------------------------------------------------------------
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module tb_alu_issue_arb;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctl;
        logic [4:0]  tag;
        logic        setf;
    } op_t;

    typedef struct packed {
        op_t         l0;
        op_t         l1;
        logic        rdy;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_v;
        logic [31:0] e_res;
        logic [4:0]  e_tag;
        logic        e_lane;
        logic [3:0]  e_flag;
    } vec_t;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_v0 = 1'b0, i_v1 = 1'b0;
    logic                o_rdy0, o_rdy1;
    logic [`D_WIDTH-1:0] i_a0 = '0, i_a1 = '0, i_b0 = '0, i_b1 = '0;
    logic [1:0]          i_ctl0 = '0, i_ctl1 = '0;
    logic [TAG_W-1:0]    i_tag0 = '0, i_tag1 = '0;
    logic                i_setf0 = 1'b0, i_setf1 = 1'b0;
    logic                o_v;
    logic                i_rdy = 1'b0;
    logic [`D_WIDTH-1:0] o_result;
    logic [TAG_W-1:0]    o_tag;
    logic                o_lane;
    logic [3:0]          o_flag;
`ifdef ALU_ARB_PERF_EN
    logic [15:0]         o_cnt0, o_cnt1, o_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    alu_issue_arb #(.TAG_W(TAG_W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_v0     (i_v0),
        .i_v1     (i_v1),
        .o_rdy0   (o_rdy0),
        .o_rdy1   (o_rdy1),
        .i_a0     (i_a0),
        .i_a1     (i_a1),
        .i_b0     (i_b0),
        .i_b1     (i_b1),
        .i_ctl0   (i_ctl0),
        .i_ctl1   (i_ctl1),
        .i_tag0   (i_tag0),
        .i_tag1   (i_tag1),
        .i_setf0  (i_setf0),
        .i_setf1  (i_setf1),
        .o_v      (o_v),
        .i_rdy    (i_rdy),
        .o_result (o_result),
        .o_tag    (o_tag),
        .o_lane   (o_lane),
        .o_flag   (o_flag)
`ifdef ALU_ARB_PERF_EN
        ,
        .o_cnt0   (o_cnt0),
        .o_cnt1   (o_cnt1),
        .o_stall  (o_stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] ctl, input logic [4:0] tag, input logic setf);
        op_t o;
        o.v = v; o.a = a; o.b = b; o.ctl = ctl; o.tag = tag; o.setf = setf;
        return o;
    endfunction

    task automatic drive(input op_t l0, input op_t l1, input logic rdy);
        i_v0 = l0.v; i_a0 = l0.a; i_b0 = l0.b; i_ctl0 = l0.ctl; i_tag0 = l0.tag; i_setf0 = l0.setf;
        i_v1 = l1.v; i_a1 = l1.a; i_b1 = l1.b; i_ctl1 = l1.ctl; i_tag1 = l1.tag; i_setf1 = l1.setf;
        i_rdy = rdy;
    endtask

    // Leaves time at posedge+2 with reset released.
    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), 1'b0);
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
    endtask

    // Applies one cycle of stimulus, checks the handshake mid-cycle, then
    // checks the registered outputs just after the edge.
    task automatic step(input string nm, input op_t l0, input op_t l1, input logic rdy,
                        input logic e_rdy0, input logic e_rdy1, input logic e_v,
                        input logic [31:0] e_res, input logic [4:0] e_tag,
                        input logic e_lane, input logic [3:0] e_flag);
        drive(l0, l1, rdy);
        #1;
        check({nm, ".rdy0"}, 32'(o_rdy0), 32'(e_rdy0));
        check({nm, ".rdy1"}, 32'(o_rdy1), 32'(e_rdy1));
        @(posedge i_clk);
        #1;
        check({nm, ".v"},    32'(o_v),      32'(e_v));
        check({nm, ".res"},  32'(o_result), e_res);
        check({nm, ".tag"},  32'(o_tag),    32'(e_tag));
        check({nm, ".lane"}, 32'(o_lane),   32'(e_lane));
        check({nm, ".flag"}, 32'(o_flag),   32'(e_flag));
    endtask

    vec_t vecs [11];

    initial begin
        op_t idle;
        idle = mk(0, 0, 0, 0, 0, 0);

        // Expected values computed by hand, starting from reset (r_last=1, flags 0).
        vecs[0]  = '{mk(1, 5, 7, 2'b00, 3, 1), idle, 1, 1, 0, 1, 32'd12, 3, 0, 4'b0000};
        vecs[1]  = '{mk(1, 3, 5, 2'b01, 4, 1), idle, 1, 1, 0, 1, 32'hFFFFFFFE, 4, 0, 4'b1000};
        vecs[2]  = '{idle, mk(1, 32'h7FFFFFFF, 1, 2'b00, 5, 1), 1, 0, 1, 1, 32'h80000000, 5, 1, 4'b1001};
        vecs[3]  = '{mk(1, 4, 4, 2'b01, 6, 0), idle, 1, 1, 0, 1, 32'd0, 6, 0, 4'b1001};
        // r_last=0, both valid: lane 1 wins; pass A from lane 1.
        vecs[4]  = '{mk(1, 9, 32'h11, 2'b10, 7, 0), mk(1, 32'h22, 3, 2'b11, 8, 0), 1, 0, 1, 1, 32'h22, 8, 1, 4'b1001};
        // r_last=1, both valid: lane 0 wins; pass B from lane 0.
        vecs[5]  = '{mk(1, 9, 32'h11, 2'b10, 7, 0), mk(1, 32'h22, 3, 2'b11, 8, 0), 1, 1, 0, 1, 32'h11, 7, 0, 4'b1001};
        // No valid lane: o_v drops, data holds.
        vecs[6]  = '{idle, idle, 1, 0, 0, 0, 32'h11, 7, 0, 4'b1001};
        // Register empty, so accepted even with i_rdy=0. -1+2 wraps to 1.
        vecs[7]  = '{mk(1, 32'hFFFFFFFF, 2, 2'b00, 9, 1), idle, 0, 1, 0, 1, 32'd1, 9, 0, 4'b0000};
        // Full and not consumed: nothing accepted, everything holds.
        vecs[8]  = '{mk(1, 1, 1, 2'b00, 12, 1), mk(1, 32'h80000000, 1, 2'b01, 10, 1), 0, 0, 0, 1, 32'd1, 9, 0, 4'b0000};
        // Consumed: r_last=0, so lane 1 wins; 0x80000000-1 overflows.
        vecs[9]  = '{mk(1, 1, 1, 2'b00, 12, 1), mk(1, 32'h80000000, 1, 2'b01, 10, 1), 1, 0, 1, 1, 32'h7FFFFFFF, 10, 1, 4'b0001};
        vecs[10] = '{mk(1, 0, 0, 2'b00, 11, 1), idle, 1, 1, 0, 1, 32'd0, 11, 0, 4'b0100};

        // ---- reset state ----
        do_reset();
        check("rst.v",    32'(o_v),      32'd0);
        check("rst.res",  32'(o_result), 32'd0);
        check("rst.tag",  32'(o_tag),    32'd0);
        check("rst.lane", 32'(o_lane),   32'd0);
        check("rst.flag", 32'(o_flag),   32'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), vecs[i].l0, vecs[i].l1, vecs[i].rdy,
                 vecs[i].e_rdy0, vecs[i].e_rdy1, vecs[i].e_v, vecs[i].e_res,
                 vecs[i].e_tag, vecs[i].e_lane, vecs[i].e_flag);
        end

        // ---- alternation: both lanes valid every cycle ----
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic even;
            even = (k % 2 == 0);
            step($sformatf("alt%0d", k),
                 mk(1, 32'(k), 0, 2'b11, 5'(16 + k), 0),
                 mk(1, 32'(k), 0, 2'b11, 5'(24 + k), 0), 1,
                 even, !even, 1, 32'(k), even ? 5'(16 + k) : 5'(24 + k), !even, 4'b0000);
        end

        // ---- back-pressure: last grant was lane 1 (tag 29, result 5) ----
        for (int k = 0; k < 3; k++) begin
            step($sformatf("bp%0d", k),
                 mk(1, 32'd40, 0, 2'b11, 5'd30, 0), mk(1, 32'd41, 0, 2'b11, 5'd31, 0), 0,
                 0, 0, 1, 32'd5, 5'd29, 1, 4'b0000);
        end
        step("bp_rel",
             mk(1, 32'd40, 0, 2'b11, 5'd30, 0), mk(1, 32'd41, 0, 2'b11, 5'd31, 0), 1,
             1, 0, 1, 32'd40, 5'd30, 0, 4'b0000);

        // ---- asynchronous reset while holding a result ----
        step("pre_rst", mk(1, 3, 5, 2'b01, 5'd2, 1), idle, 1,
             1, 0, 1, 32'hFFFFFFFE, 5'd2, 0, 4'b1000);
        drive(mk(1, 7, 0, 2'b11, 5'd13, 0), mk(1, 8, 0, 2'b11, 5'd14, 0), 1'b0);
        #3 i_rst_n = 1'b0;
        #1;
        check("arst.v",    32'(o_v),    32'd0);
        check("arst.flag", 32'(o_flag), 32'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        step("arst.first", mk(1, 7, 0, 2'b11, 5'd13, 0), mk(1, 8, 0, 2'b11, 5'd14, 0), 1,
             1, 0, 1, 32'd7, 5'd13, 0, 4'b0000);

`ifdef ALU_ARB_PERF_EN
        // ---- performance counters ----
        do_reset();
        check("perf.rst0", 32'(o_cnt0), 32'd0);
        for (int k = 0; k < 10; k++) begin
            drive(mk(1, 1, 1, 2'b00, 1, 0), idle, 1'b1);
            @(posedge i_clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            drive(idle, mk(1, 1, 1, 2'b00, 2, 0), 1'b1);
            @(posedge i_clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 1, 1, 2'b00, 1, 0), idle, 1'b0);
            @(posedge i_clk); #1;
        end
        drive(idle, idle, 1'b1);
        @(posedge i_clk); #1;
        check("perf.cnt0",  32'(o_cnt0),  32'd10);
        check("perf.cnt1",  32'(o_cnt1),  32'd4);
        check("perf.stall", 32'(o_stall), 32'd3);
        drive(mk(1, 1, 1, 2'b00, 1, 0), idle, 1'b1);
        for (int k = 0; k < 65530; k++) begin
            @(posedge i_clk);
        end
        #1;
        check("perf.sat0", 32'(o_cnt0), 32'h0000FFFF);
        check("perf.cnt1_hold", 32'(o_cnt1), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_issue_arb.md
Name: alu_issue_arb

Overview:
- Shares the single `alu` instance between the two issue lanes of the superscalar core.
- Each cycle a round-robin arbiter grants at most one lane and drives the granted operands and control into `alu`.
- The result, tag, lane id and flags are captured in a one-entry output register with a valid/ready handshake toward writeback.
- Keeps the architectural NZCV flag register, which is updated only by ops that request it.

Parameters:
- TAG_W, 5, width of the destination/ROB tag carried alongside each op.
- Data width is `D_WIDTH from param.v. It is not a module parameter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_v0 / i_v1  in  1  lane 0/1 has an op.
- o_rdy0 / o_rdy1  out  1  lane 0/1 op accepted this cycle.
- i_a0 / i_a1  in  `D_WIDTH  operand A, lane 0/1.
- i_b0 / i_b1  in  `D_WIDTH  operand B, lane 0/1.
- i_ctl0 / i_ctl1  in  2  ALU control: 00 A+B, 01 A-B, 10 pass B, 11 pass A.
- i_tag0 / i_tag1  in  TAG_W  tag, lane 0/1.
- i_setf0 / i_setf1  in  1  op writes the flag register.
- o_v  out  1  output register holds a result.
- i_rdy  in  1  writeback consumes the result.
- o_result  out  `D_WIDTH  registered ALU result.
- o_tag  out  TAG_W  registered tag.
- o_lane  out  1  lane that issued the held result.
- o_flag  out  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (async assert, sync release):
  - o_v=0, o_result=0, o_tag=0, o_lane=0, o_flag=4'b0000.
  - Last-grant pointer r_last=1, so lane 0 wins first.
- Accept condition:
  - acc = !o_v || i_rdy.
  - When acc=0, o_rdy0=o_rdy1=0 and all registers hold.
- Arbitration (combinational, valid only when acc=1):
  - Only i_v0 valid: grant lane 0.
  - Only i_v1 valid: grant lane 1.
  - Both valid: grant lane !r_last.
  - Neither valid: no grant.
- o_rdyK = acc && grantK.
  - o_rdy depends combinationally on i_v. Producers must not make i_v depend on o_rdy.
- ALU mux: the granted lane's a/b/ctl drive `alu`. With no grant, lane 0 inputs are muxed in and the result is ignored.
- On a clock edge with a grant:
  - o_v<=1; o_result<=alu result; o_tag<=granted tag; o_lane<=granted lane; r_last<=granted lane.
  - If the granted lane's setf=1: o_flag <= alu o_Flag.
  - C is always 0 as produced by `alu`.
- On a clock edge with acc=1 and no grant: o_v<=0. Data, flags and r_last hold.
- Consume and new grant in the same cycle: the output register is overwritten with the new result and o_v stays 1, giving full throughput of one op per cycle.
- Latency: exactly 1 cycle from accept to o_v.
- Ordering and fairness:
  - Results leave in grant order.
  - A continuously valid lane waits at most one grant.
- Control encodings are all decoded, so there are no illegal values.
- Arithmetic wraps modulo 2^`D_WIDTH.
- Reset mid-operation discards the held result immediately (o_v=0). A pending lane op is not accepted and must be re-presented by its lane.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds ports o_cnt0 and o_cnt1, each out 16.
  - Each counts grants to its lane and saturates at 16'hFFFF.
  - Adds port o_stall, out 16: counts cycles with (i_v0||i_v1) && !acc, also saturating.
  - All counters reset to 0 under i_rst_n.
- Not defined: none of these ports or counters exist. Core behaviour is identical in both builds.

Test Plan:
- Lane 0 only, ctl=00, a=5, b=7, tag=3, setf=1, i_rdy=1:
  - o_rdy0=1 that cycle.
  - Next cycle: o_v=1, o_result=12, o_tag=3, o_lane=0, o_flag=0000.
- After reset, both lanes valid every cycle with distinct tags, i_rdy=1:
  - Grants alternate lane0, lane1, lane0...
  - o_lane toggles every cycle; o_v stays 1.
- Hold i_rdy=0 while o_v=1 with both lanes valid:
  - o_rdy0=o_rdy1=0; o_result and o_tag stable.
  - Raise i_rdy: the next grant goes to !r_last and loads on that edge.
- Flag updates, one op per step, each with the stated setf:
  - ctl=01, a=3, b=5, setf=1: o_result=32'hFFFFFFFE, o_flag=1000.
  - ctl=00, a=32'h7FFFFFFF, b=1, setf=1: o_flag=1001.
  - ctl=01, a=4, b=4, setf=0: o_result=0, o_flag stays 1001.
- Assert i_rst_n=0 asynchronously while o_v=1 and lanes are valid:
  - o_v drops to 0 before the next edge; o_flag=0.
  - After release, lane 0 is granted first.
- With ALU_ARB_PERF_EN defined:
  - 10 grants to lane 0, 4 to lane 1 and 3 back-pressured cycles give o_cnt0=10, o_cnt1=4, o_stall=3.
  - Preload near the maximum and check each counter saturates at 16'hFFFF.
